ula_arbiter: RTL and testbench

//  Shares one 32-bit ULA instance between two requesters (r0: EX-stage issue, r1: auxiliary/address unit).

---
 rtl/ula_arbiter_if.sv | 47 ++++
 rtl/ula_arbiter.sv | 150 +++++++++++++++
 tb/tb_ula_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_arbiter_if.sv
// ula_arbiter_if: request and response bundle of the shared-ULA arbiter.
//   r0_* / r1_* : two requesters (valid, ready, op, a, b, shamt)
//   rsp_*       : tagged response (valid, ready, id, result, zero)
//   master      : requester/consumer side
//   slave       : arbiter side
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. The producer keeps its payload stable while valid
// is high and the transfer has not happened yet. A requester may withdraw
// valid before it is accepted. Ready may depend combinationally on valid.
interface ula_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [3:0]  r0_op;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic [4:0]  r0_shamt;

  logic        r1_valid;
  logic        r1_ready;
  logic [3:0]  r1_op;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic [4:0]  r1_shamt;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b, r0_shamt,
    output r1_valid, r1_op, r1_a, r1_b, r1_shamt,
    output rsp_ready,
    input  r0_ready, r1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b, r0_shamt,
    input  r1_valid, r1_op, r1_a, r1_b, r1_shamt,
    input  rsp_ready,
    output r0_ready, r1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one 32-bit ULA between two requesters.
//   RR_EN     : 1 = round-robin on ties, 0 = r0 always wins ties
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : ula_arbiter_if.slave (requests in, tagged response out)
//   dbg_state : current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// Flow: accept edge loads operands (IDLE/RESP -> EXEC), the next edge
// captures the ULA result into the response register (EXEC -> RESP), and the
// response is held until rsp_ready. A new request can be accepted in the same
// cycle the response retires, giving one result every two cycles.
module ula_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  ula_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        grant_id;
  logic        any_req;
  logic        can_accept;
  logic        accept;
  logic        load_rsp;

  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  shamt_q;
  logic        id_q;
  logic        last_id;

  logic [31:0] ula_y;
  logic        ula_zero;

  // Grant: a tie goes to the requester not served last (RR) or to r0.
  always_comb begin
    any_req  = bus.r0_valid | bus.r1_valid;
    grant_id = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
      grant_id = RR_EN ? ~last_id : 1'b0;
    end else if (bus.r1_valid) begin
      grant_id = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = accept ? S_EXEC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. Ready is masked by rst_n so it stays low while reset is held.
  always_comb begin
    can_accept    = (state == S_IDLE) || ((state == S_RESP) && bus.rsp_ready);
    accept        = can_accept && any_req;
    bus.r0_ready  = rst_n && can_accept && bus.r0_valid && !grant_id;
    bus.r1_ready  = rst_n && can_accept && bus.r1_valid && grant_id;
    bus.rsp_valid = (state == S_RESP);
    load_rsp      = (state == S_EXEC);
    dbg_state     = state;
  end

  // Operand registers; last_id resets to 1 so r0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      id_q    <= 1'b0;
      last_id <= 1'b1;
    end else if (accept) begin
      id_q    <= grant_id;
      last_id <= grant_id;
      if (grant_id) begin
        op_q    <= bus.r1_op;
        a_q     <= bus.r1_a;
        b_q     <= bus.r1_b;
        shamt_q <= bus.r1_shamt;
      end else begin
        op_q    <= bus.r0_op;
        a_q     <= bus.r0_a;
        b_q     <= bus.r0_b;
        shamt_q <= bus.r0_shamt;
      end
    end
  end

  // ULA: shifts act on In2; variable shifts take the amount from In1[4:0].
  // Unassigned opcode 1001 falls into the default (add).
  always_comb begin
    ula_y = a_q + b_q;
    case (op_q)
      4'b0000: ula_y = a_q & b_q;
      4'b0001: ula_y = a_q | b_q;
      4'b0010: ula_y = a_q + b_q;
      4'b0011: ula_y = b_q << shamt_q;
      4'b0100: ula_y = $signed(b_q) >>> shamt_q;
      4'b0101: ula_y = b_q >> shamt_q;
      4'b0110: ula_y = a_q - b_q;
      4'b0111: ula_y = {31'b0, ($signed(a_q) < $signed(b_q))};
      4'b1000: ula_y = {31'b0, (a_q < b_q)};
      4'b1010: ula_y = $signed(b_q) >>> a_q[4:0];
      4'b1011: ula_y = {b_q[15:0], 16'h0000};
      4'b1100: ula_y = ~(a_q | b_q);
      4'b1101: ula_y = a_q ^ b_q;
      4'b1110: ula_y = b_q << a_q[4:0];
      4'b1111: ula_y = b_q >> a_q[4:0];
      default: ula_y = a_q + b_q;
    endcase
    ula_zero = (ula_y == 32'h0);
  end

  // Response register: written only on the EXEC edge, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_id     <= 1'b0;
    end else if (load_rsp) begin
      bus.rsp_result <= ula_y;
      bus.rsp_zero   <= ula_zero;
      bus.rsp_id     <= id_q;
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: checks the shared-ULA arbiter with directed scenarios and a
// randomized run against a transaction-level reference model. Two DUTs share
// clock and reset: dut_rr (round-robin) and dut_fp (fixed priority).
module tb_ula_arbiter;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_rr;
  logic [1:0] dbg_fp;

  ula_arbiter_if bus_rr ();
  ula_arbiter_if bus_fp ();

  ula_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr), .dbg_state(dbg_rr));
  ula_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp), .dbg_state(dbg_fp));

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  bit          exp_id_q[$];
  int          exp_cyc_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ula_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    longint ua, ub, sb, sa, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:    r = ua & ub;
      4'd1:    r = ua | ub;
      4'd3:    r = ub * (64'd1 << sh);
      4'd4:    r = sb >>> sh;
      4'd5:    r = ub / (64'd1 << sh);
      4'd6:    r = ua - ub;
      4'd7:    r = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:    r = (ua < ub) ? 64'd1 : 64'd0;
      4'd10:   r = sb >>> a[4:0];
      4'd11:   r = (ub % 65536) * 65536;
      4'd12:   r = ~(ua | ub);
      4'd13:   r = ua ^ ub;
      4'd14:   r = ub * (64'd1 << a[4:0]);
      4'd15:   r = ub / (64'd1 << a[4:0]);
      default: r = ua + ub;
    endcase
    return r[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_r0(input bit v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
    bus_rr.r0_valid = v; bus_rr.r0_op = op; bus_rr.r0_a = a; bus_rr.r0_b = b; bus_rr.r0_shamt = sh;
  endtask

  task automatic drive_r1(input bit v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
    bus_rr.r1_valid = v; bus_rr.r1_op = op; bus_rr.r1_a = a; bus_rr.r1_b = b; bus_rr.r1_shamt = sh;
  endtask

  task automatic idle_all();
    drive_r0(0, 4'd0, 32'd0, 32'd0, 5'd0);
    drive_r1(0, 4'd0, 32'd0, 32'd0, 5'd0);
    bus_rr.rsp_ready = 1'b0;
    bus_fp.r0_valid = 0; bus_fp.r0_op = 0; bus_fp.r0_a = 0; bus_fp.r0_b = 0; bus_fp.r0_shamt = 0;
    bus_fp.r1_valid = 0; bus_fp.r1_op = 0; bus_fp.r1_a = 0; bus_fp.r1_b = 0; bus_fp.r1_shamt = 0;
    bus_fp.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); exp_id_q.delete(); exp_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    @(negedge clk);
    drive_r0(1, 4'd2, 32'd1, 32'd1, 5'd0);
    drive_r1(1, 4'd2, 32'd1, 32'd1, 5'd0);
    bus_rr.rsp_ready = 1'b1;
    #1;
    tests++; if (bus_rr.r0_ready !== 1'b0) begin fails++; $display("FAIL reset_r0_ready: got %b want 0", bus_rr.r0_ready); end
    tests++; if (bus_rr.r1_ready !== 1'b0) begin fails++; $display("FAIL reset_r1_ready: got %b want 0", bus_rr.r1_ready); end
    tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", bus_rr.rsp_valid); end
    tests++; if (bus_rr.rsp_result !== 32'h0) begin fails++; $display("FAIL reset_rsp_result: got %h want 0", bus_rr.rsp_result); end
    tests++; if (bus_rr.rsp_zero !== 1'b0) begin fails++; $display("FAIL reset_rsp_zero: got %b want 0", bus_rr.rsp_zero); end
    tests++; if (bus_rr.rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id: got %b want 0", bus_rr.rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    bus_rr.rsp_ready = 1'b1;
    drive_r0(1, 4'b0010, 32'd5, 32'd7, 5'd0);
    #1;
    tests++; if (bus_rr.r0_ready !== 1'b1) begin fails++; $display("FAIL single_r0_ready: got %b want 1", bus_rr.r0_ready); end
    tests++; if (bus_rr.r1_ready !== 1'b0) begin fails++; $display("FAIL single_r1_ready: got %b want 0", bus_rr.r1_ready); end
    @(negedge clk);
    drive_r0(0, 4'd0, 32'd0, 32'd0, 5'd0);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_exec_valid: got %b want 0", bus_rr.rsp_valid); end
    @(negedge clk);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b1) begin fails++; $display("FAIL single_rsp_valid: got %b want 1", bus_rr.rsp_valid); end
    tests++; if (bus_rr.rsp_result !== 32'd12) begin fails++; $display("FAIL single_result: got %h want c", bus_rr.rsp_result); end
    tests++; if (bus_rr.rsp_zero !== 1'b0) begin fails++; $display("FAIL single_zero: got %b want 0", bus_rr.rsp_zero); end
    tests++; if (bus_rr.rsp_id !== 1'b0) begin fails++; $display("FAIL single_id: got %b want 0", bus_rr.rsp_id); end
    @(negedge clk);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_retire: got %b want 0", bus_rr.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op0, op1; logic [31:0] a0, a1, b0, b1; logic [4:0] s0, s1;
    bit acc0, acc1, exp_next_id, exp_v;
    int n_acc;
    do_reset();
    acc0 = 1; acc1 = 1; exp_next_id = 0; n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus_rr.rsp_ready = 1'b1;
      if (acc0) begin op0 = 4'($urandom_range(0, 15)); a0 = $urandom; b0 = $urandom; s0 = 5'($urandom_range(0, 31)); end
      if (acc1) begin op1 = 4'($urandom_range(0, 15)); a1 = $urandom; b1 = $urandom; s1 = 5'($urandom_range(0, 31)); end
      drive_r0(1, op0, a0, b0, s0);
      drive_r1(1, op1, a1, b1, s1);
      #1;
      exp_v = (c >= 2) && (c % 2 == 0);
      tests++; if (bus_rr.rsp_valid !== exp_v) begin fails++; $display("FAIL b2b_cadence c=%0d: got %b want %b", c, bus_rr.rsp_valid, exp_v); end
      if (bus_rr.rsp_valid === 1'b1 && exp_q.size() > 0) begin
        tests++; if (bus_rr.rsp_result !== exp_q[0]) begin fails++; $display("FAIL b2b_result: got %h want %h", bus_rr.rsp_result, exp_q[0]); end
        tests++; if (bus_rr.rsp_id !== exp_id_q[0]) begin fails++; $display("FAIL b2b_id: got %b want %b", bus_rr.rsp_id, exp_id_q[0]); end
        void'(exp_q.pop_front()); void'(exp_id_q.pop_front());
      end
      tests++; if (bus_rr.r0_ready === 1'b1 && bus_rr.r1_ready === 1'b1) begin fails++; $display("FAIL b2b_both_ready: got 11 want at most one"); end
      acc0 = (bus_rr.r0_ready === 1'b1);
      acc1 = !acc0 && (bus_rr.r1_ready === 1'b1);
      if (acc0 || acc1) begin
        tests++; if (acc1 !== exp_next_id) begin fails++; $display("FAIL b2b_grant_order: got id %b want %b", acc1, exp_next_id); end
        exp_next_id = ~exp_next_id;
        n_acc++;
        exp_q.push_back(acc1 ? ula_model(op1, a1, b1, s1) : ula_model(op0, a0, b0, s0));
        exp_id_q.push_back(acc1);
      end
    end
    tests++; if (n_acc != 6) begin fails++; $display("FAIL b2b_accept_count: got %0d want 6", n_acc); end
    @(negedge clk);
    idle_all(); bus_rr.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    drive_r1(1, 4'b0110, 32'd3, 32'd3, 5'd0);
    #1;
    tests++; if (bus_rr.r1_ready !== 1'b1) begin fails++; $display("FAIL stall_r1_accept: got %b want 1", bus_rr.r1_ready); end
    @(negedge clk);
    drive_r1(1, 4'b1101, 32'h1234, 32'h1234, 5'd0);
    drive_r0(1, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd0);
    #1;
    tests++; if ({bus_rr.r0_ready, bus_rr.r1_ready} !== 2'b00) begin fails++; $display("FAIL stall_exec_ready: got %b want 00", {bus_rr.r0_ready, bus_rr.r1_ready}); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      tests++; if (bus_rr.rsp_valid !== 1'b1) begin fails++; $display("FAIL stall_valid k=%0d: got %b want 1", k, bus_rr.rsp_valid); end
      tests++; if (bus_rr.rsp_result !== 32'h0) begin fails++; $display("FAIL stall_result k=%0d: got %h want 0", k, bus_rr.rsp_result); end
      tests++; if (bus_rr.rsp_zero !== 1'b1) begin fails++; $display("FAIL stall_zero k=%0d: got %b want 1", k, bus_rr.rsp_zero); end
      tests++; if (bus_rr.rsp_id !== 1'b1) begin fails++; $display("FAIL stall_id k=%0d: got %b want 1", k, bus_rr.rsp_id); end
      tests++; if ({bus_rr.r0_ready, bus_rr.r1_ready} !== 2'b00) begin fails++; $display("FAIL stall_ready k=%0d: got %b want 00", k, {bus_rr.r0_ready, bus_rr.r1_ready}); end
    end
    @(negedge clk);
    bus_rr.rsp_ready = 1'b1;
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b1) begin fails++; $display("FAIL stall_release_valid: got %b want 1", bus_rr.rsp_valid); end
    tests++; if ({bus_rr.r0_ready, bus_rr.r1_ready} !== 2'b10) begin fails++; $display("FAIL stall_release_grant: got %b want 10", {bus_rr.r0_ready, bus_rr.r1_ready}); end
    @(negedge clk);
    drive_r0(0, 4'd0, 32'd0, 32'd0, 5'd0);
    drive_r1(0, 4'd0, 32'd0, 32'd0, 5'd0);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL stall_exec2_valid: got %b want 0", bus_rr.rsp_valid); end
    @(negedge clk);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b1) begin fails++; $display("FAIL stall_rsp2_valid: got %b want 1", bus_rr.rsp_valid); end
    tests++; if (bus_rr.rsp_result !== 32'h0000F000) begin fails++; $display("FAIL stall_rsp2_result: got %h want 0000f000", bus_rr.rsp_result); end
    tests++; if (bus_rr.rsp_id !== 1'b0) begin fails++; $display("FAIL stall_rsp2_id: got %b want 0", bus_rr.rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    logic [3:0] op0; logic [31:0] a0, b0; logic [4:0] s0;
    bit acc0, exp_r;
    int n_rsp;
    do_reset();
    acc0 = 1; n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (acc0) begin op0 = 4'($urandom_range(0, 15)); a0 = $urandom; b0 = $urandom; s0 = 5'($urandom_range(0, 31)); end
      bus_fp.r0_valid = 1; bus_fp.r0_op = op0; bus_fp.r0_a = a0; bus_fp.r0_b = b0; bus_fp.r0_shamt = s0;
      bus_fp.r1_valid = 1; bus_fp.r1_op = 4'd2; bus_fp.r1_a = 32'd9; bus_fp.r1_b = 32'd9; bus_fp.r1_shamt = 5'd0;
      bus_fp.rsp_ready = 1'b1;
      #1;
      tests++; if (bus_fp.r1_ready !== 1'b0) begin fails++; $display("FAIL fp_r1_ready c=%0d: got %b want 0", c, bus_fp.r1_ready); end
      exp_r = (c % 2 == 0);
      tests++; if (bus_fp.r0_ready !== exp_r) begin fails++; $display("FAIL fp_r0_ready c=%0d: got %b want %b", c, bus_fp.r0_ready, exp_r); end
      if (bus_fp.rsp_valid === 1'b1) begin
        n_rsp++;
        tests++; if (bus_fp.rsp_id !== 1'b0) begin fails++; $display("FAIL fp_rsp_id: got %b want 0", bus_fp.rsp_id); end
        if (exp_q.size() > 0) begin
          tests++; if (bus_fp.rsp_result !== exp_q[0]) begin fails++; $display("FAIL fp_result: got %h want %h", bus_fp.rsp_result, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      acc0 = (bus_fp.r0_ready === 1'b1);
      if (acc0) exp_q.push_back(ula_model(op0, a0, b0, s0));
    end
    tests++; if (n_rsp != 5) begin fails++; $display("FAIL fp_rsp_count: got %0d want 5", n_rsp); end
    @(negedge clk);
    idle_all();
    bus_fp.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ops();
    logic [3:0]  v_op[7] = '{4'b0100, 4'b0111, 4'b1000, 4'b1001, 4'b1011, 4'b1010, 4'b1100};
    logic [31:0] v_a[7]  = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h0, 32'd8, 32'h0};
    logic [31:0] v_b[7]  = '{32'h80000000, 32'd1, 32'd1, 32'd7, 32'h00001234, 32'h80000000, 32'h0};
    logic [4:0]  v_s[7]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] v_e[7]  = '{32'hF8000000, 32'd1, 32'd0, 32'd12, 32'h12340000, 32'hFF800000, 32'hFFFFFFFF};
    logic [3:0] op; logic [31:0] a, b, e; logic [4:0] s;
    do_reset();
    for (int i = 0; i < 47; i++) begin
      if (i < 7) begin
        op = v_op[i]; a = v_a[i]; b = v_b[i]; s = v_s[i]; e = v_e[i];
      end else begin
        op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; s = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) b = a;
        e = ula_model(op, a, b, s);
      end
      @(negedge clk);
      bus_rr.rsp_ready = 1'b1;
      drive_r0(1, op, a, b, s);
      #1;
      tests++; if (bus_rr.r0_ready !== 1'b1) begin fails++; $display("FAIL ops_ready i=%0d: got %b want 1", i, bus_rr.r0_ready); end
      @(negedge clk);
      drive_r0(0, 4'd0, 32'd0, 32'd0, 5'd0);
      @(negedge clk);
      #1;
      tests++; if (bus_rr.rsp_valid !== 1'b1) begin fails++; $display("FAIL ops_valid i=%0d: got %b want 1", i, bus_rr.rsp_valid); end
      tests++; if (bus_rr.rsp_result !== e) begin fails++; $display("FAIL ops_result i=%0d op=%b: got %h want %h", i, op, bus_rr.rsp_result, e); end
      tests++; if (bus_rr.rsp_zero !== (e == 32'h0)) begin fails++; $display("FAIL ops_zero i=%0d: got %b want %b", i, bus_rr.rsp_zero, (e == 32'h0)); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    do_reset();
    @(negedge clk);
    bus_rr.rsp_ready = 1'b1;
    drive_r0(1, 4'b0010, 32'd1, 32'd2, 5'd0);
    #1;
    tests++; if (bus_rr.r0_ready !== 1'b1) begin fails++; $display("FAIL rexec_accept: got %b want 1", bus_rr.r0_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    drive_r0(1, 4'b0010, 32'd10, 32'd20, 5'd0);
    drive_r1(1, 4'b0010, 32'd100, 32'd200, 5'd0);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL rexec_valid_now: got %b want 0", bus_rr.rsp_valid); end
    tests++; if ({bus_rr.r0_ready, bus_rr.r1_ready} !== 2'b00) begin fails++; $display("FAIL rexec_ready_in_reset: got %b want 00", {bus_rr.r0_ready, bus_rr.r1_ready}); end
    @(negedge clk);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL rexec_valid_held: got %b want 0", bus_rr.rsp_valid); end
    tests++; if (bus_rr.rsp_result !== 32'h0) begin fails++; $display("FAIL rexec_result_cleared: got %h want 0", bus_rr.rsp_result); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if ({bus_rr.r0_ready, bus_rr.r1_ready} !== 2'b10) begin fails++; $display("FAIL rexec_tie_after_reset: got %b want 10", {bus_rr.r0_ready, bus_rr.r1_ready}); end
    @(negedge clk);
    drive_r0(0, 4'd0, 32'd0, 32'd0, 5'd0);
    drive_r1(0, 4'd0, 32'd0, 32'd0, 5'd0);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL rexec_exec_valid: got %b want 0", bus_rr.rsp_valid); end
    @(negedge clk);
    #1;
    tests++; if (bus_rr.rsp_valid !== 1'b1) begin fails++; $display("FAIL rexec_rsp_valid: got %b want 1", bus_rr.rsp_valid); end
    tests++; if (bus_rr.rsp_result !== 32'd30) begin fails++; $display("FAIL rexec_result: got %h want 1e", bus_rr.rsp_result); end
    tests++; if (bus_rr.rsp_id !== 1'b0) begin fails++; $display("FAIL rexec_id: got %b want 0", bus_rr.rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit v0, v1, acc0, acc1, last_acc, front_seen, exp_can, exp0, exp1, exp_v;
    logic [3:0] op0, op1; logic [31:0] a0, a1, b0, b1; logic [4:0] s0, s1;
    int outstanding;
    do_reset();
    v0 = 0; v1 = 0; acc0 = 0; acc1 = 0; last_acc = 1; front_seen = 0;
    op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; s0 = 0; s1 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (acc0) v0 = 0;
      if (acc1) v1 = 0;
      if (v0 && $urandom_range(0, 7) == 0) v0 = 0;
      else if (!v0 && $urandom_range(0, 1) == 1) begin
        v0 = 1; op0 = 4'($urandom_range(0, 15)); a0 = $urandom; b0 = $urandom; s0 = 5'($urandom_range(0, 31));
      end
      if (v1 && $urandom_range(0, 7) == 0) v1 = 0;
      else if (!v1 && $urandom_range(0, 1) == 1) begin
        v1 = 1; op1 = 4'($urandom_range(0, 15)); a1 = $urandom; b1 = $urandom; s1 = 5'($urandom_range(0, 31));
      end
      drive_r0(v0, op0, a0, b0, s0);
      drive_r1(v1, op1, a1, b1, s1);
      bus_rr.rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      outstanding = exp_q.size();
      if (outstanding == 0) begin
        tests++; if (bus_rr.rsp_valid !== 1'b0) begin fails++; $display("FAIL rand_spurious_rsp c=%0d: got %b want 0", c, bus_rr.rsp_valid); end
      end else begin
        if (!front_seen) begin
          exp_v = (c >= exp_cyc_q[0] + 2);
          tests++; if (bus_rr.rsp_valid !== exp_v) begin fails++; $display("FAIL rand_latency c=%0d: got %b want %b", c, bus_rr.rsp_valid, exp_v); end
          if (bus_rr.rsp_valid === 1'b1) front_seen = 1;
        end else begin
          tests++; if (bus_rr.rsp_valid !== 1'b1) begin fails++; $display("FAIL rand_rsp_dropped c=%0d: got %b want 1", c, bus_rr.rsp_valid); end
        end
        if (front_seen && bus_rr.rsp_valid === 1'b1) begin
          tests++; if (bus_rr.rsp_result !== exp_q[0]) begin fails++; $display("FAIL rand_result c=%0d: got %h want %h", c, bus_rr.rsp_result, exp_q[0]); end
          tests++; if (bus_rr.rsp_zero !== (exp_q[0] == 32'h0)) begin fails++; $display("FAIL rand_zero c=%0d: got %b want %b", c, bus_rr.rsp_zero, (exp_q[0] == 32'h0)); end
          tests++; if (bus_rr.rsp_id !== exp_id_q[0]) begin fails++; $display("FAIL rand_id c=%0d: got %b want %b", c, bus_rr.rsp_id, exp_id_q[0]); end
        end
      end
      exp_can = (outstanding == 0) || (front_seen && bus_rr.rsp_ready);
      if (front_seen && bus_rr.rsp_valid === 1'b1 && bus_rr.rsp_ready) begin
        void'(exp_q.pop_front()); void'(exp_id_q.pop_front()); void'(exp_cyc_q.pop_front());
        front_seen = 0;
      end
      exp0 = exp_can && (v1 ? (last_acc == 1'b1) : 1'b1);
      exp1 = exp_can && (v0 ? (last_acc == 1'b0) : 1'b1);
      if (v0) begin
        tests++; if (bus_rr.r0_ready !== exp0) begin fails++; $display("FAIL rand_r0_ready c=%0d: got %b want %b", c, bus_rr.r0_ready, exp0); end
      end
      if (v1) begin
        tests++; if (bus_rr.r1_ready !== exp1) begin fails++; $display("FAIL rand_r1_ready c=%0d: got %b want %b", c, bus_rr.r1_ready, exp1); end
      end
      acc0 = v0 && (bus_rr.r0_ready === 1'b1);
      acc1 = v1 && (bus_rr.r1_ready === 1'b1) && !acc0;
      if (acc0) begin
        exp_q.push_back(ula_model(op0, a0, b0, s0)); exp_id_q.push_back(1'b0); exp_cyc_q.push_back(c); last_acc = 0;
      end else if (acc1) begin
        exp_q.push_back(ula_model(op1, a1, b1, s1)); exp_id_q.push_back(1'b1); exp_cyc_q.push_back(c); last_acc = 1;
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fixed_priority();
    test_ops();
    test_reset_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
